// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, mem_rw and funct3 codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved funct3 codes fall through to a full-word access.
  function automatic size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data steering and load byte/half extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (size_of(st_funct3_i))
      SZ_B: begin
        st_be_o    = 4'b0001 << st_offset_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_H: begin
        st_be_o    = 4'b0011 << {st_offset_i[1], 1'b0};
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (ld_offset_i)
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      2'd3:    ld_byte = ld_word_i[31:24];
      default: ;
    endcase
    ld_half = ld_offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'b0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'b0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one valid/ready bus transaction per core memory op, stalling the core until DONE.
// Optional misaligned-access trap selected by defining LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mem_rw,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  state_e              state_q, state_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          offset_q, offset_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                fault_q, fault_d;

  logic        is_store;
  logic        mem_op;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign is_store = (mem_rw == MEM_STORE);
  assign mem_op   = (mem_rw == MEM_LOAD) || is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((size_of(funct3) == SZ_H) && addr[0]) ||
                      ((size_of(funct3) == SZ_W) && (addr[1:0] != 2'b00));
`else
  // Sub-alignment address bits are simply dropped by the lane logic.
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .st_funct3_i (funct3),
    .st_offset_i (addr[1:0]),
    .st_wdata_i  (wdata),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (funct3_q),
    .ld_offset_i (offset_q),
    .ld_word_i   (bus_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ST_REQ;
            bus_we_d    = is_store;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = is_store ? st_be : 4'b1111;
            bus_wdata_d = is_store ? st_wdata : '0;
            funct3_d    = funct3;
            offset_d    = addr[1:0];
          end
        end
      end
      ST_REQ: begin
        if (bus_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (bus_rsp_valid) begin
          state_d = ST_DONE;
          rdata_d = bus_we_q ? '0 : ld_data;
          fault_d = 1'b0;
        end
      end
      ST_DONE: begin
        // Retire only; the op still on mem_rw belongs to the instruction now completing.
        state_d = ST_IDLE;
        fault_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      funct3_q    <= '0;
      offset_q    <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign stall         = ((state_q == ST_IDLE) && mem_op) ||
                         (state_q == ST_REQ) || (state_q == ST_RSP);
  assign bus_req_valid = (state_q == ST_REQ);
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign rdata         = rdata_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mem_rw = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_rw        (mem_rw),
    .funct3        (funct3),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .rdata         (rdata),
    .fault         (fault),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int unsigned m_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n = m_bytes(f3);
    if (n == 1) return a % 4;
    if (n == 2) return ((a % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input bit store, input logic [2:0] f3, input logic [31:0] a);
    if (!store) return 4'hF;
    return 4'(((1 << m_bytes(f3)) - 1) << m_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_bytes(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int unsigned n = m_bytes(f3);
    longint v;
    if (n == 4) return word;
    v = longint'((word >> (8 * m_off(f3, a))) & ((32'd1 << (8 * n)) - 1));
    if (f3[2] == 1'b0 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
    return 32'(v);
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (m_bytes(f3) == 2 && (a % 2) != 0) || (m_bytes(f3) == 4 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One memory instruction as the core presents it; entered and left at a falling edge in IDLE.
  task automatic run_op(input string name, input logic [1:0] rw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int ready_wait);
    bit          st;
    logic [31:0] exp_rd;
    st = (rw == 2'b10);
    mem_rw = rw; funct3 = f3; addr = a; wdata = wd;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s stall_issue got=%b exp=1", name, stall); end

    if (m_misaligned(f3, a)) begin
      @(negedge clk);
      checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL %s trap_req_valid got=%b exp=0", name, bus_req_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s trap_stall got=%b exp=0", name, stall); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL %s trap_fault got=%b exp=1", name, fault); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL %s trap_rdata got=%h exp=0", name, rdata); end
      mem_rw = 2'b00;
      @(negedge clk);
      checks++; if (fault !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL %s trap_after fault=%b valid=%b exp=0/0", name, fault, bus_req_valid); end
      return;
    end

    exp_rd = st ? 32'h0 : m_load(f3, a, word);
    @(negedge clk);
    for (int i = 0; i <= ready_wait; i++) begin
      checks++; if (bus_req_valid !== 1'b1) begin errors++; $display("FAIL %s req_valid[%0d] got=%b exp=1", name, i, bus_req_valid); end
      checks++; if (bus_we !== st) begin errors++; $display("FAIL %s bus_we[%0d] got=%b exp=%b", name, i, bus_we, st); end
      checks++; if (bus_addr !== (a & ~32'h3)) begin errors++; $display("FAIL %s bus_addr[%0d] got=%h exp=%h", name, i, bus_addr, a & ~32'h3); end
      checks++; if (bus_be !== m_be(st, f3, a)) begin errors++; $display("FAIL %s bus_be[%0d] got=%b exp=%b", name, i, bus_be, m_be(st, f3, a)); end
      if (st) begin
        checks++; if (bus_wdata !== m_wdata(f3, wd)) begin errors++; $display("FAIL %s bus_wdata[%0d] got=%h exp=%h", name, i, bus_wdata, m_wdata(f3, wd)); end
      end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s stall_req[%0d] got=%b exp=1", name, i, stall); end
      if (i == ready_wait) bus_req_ready = 1'b1;
      @(negedge clk);
    end
    bus_req_ready = 1'b0;

    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_req_valid got=%b exp=0", name, bus_req_valid); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s stall_rsp got=%b exp=1", name, stall); end
    bus_rsp_valid = 1'b1; bus_rdata = word;
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rdata = $urandom;

    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s stall_done got=%b exp=0", name, stall); end
    checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL %s rdata_done got=%h exp=%h", name, rdata, exp_rd); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL %s fault_done got=%b exp=0", name, fault); end
    mem_rw = 2'b00;
    @(negedge clk);
    checks++; if (bus_req_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL %s relaunch valid=%b stall=%b exp=0/0", name, bus_req_valid, stall); end
    checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL %s rdata_hold got=%h exp=%h", name, rdata, exp_rd); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus_req_valid !== 1'b0 || bus_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_ctrl valid=%b we=%b stall=%b exp=0/0/0", bus_req_valid, bus_we, stall); end
    checks++; if (bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus addr=%h be=%b wdata=%h exp=0", bus_addr, bus_be, bus_wdata); end
    checks++; if (rdata !== 32'h0 || fault !== 1'b0) begin errors++; $display("FAIL reset_out rdata=%h fault=%b exp=0/0", rdata, fault); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_op("lw_0x100", 2'b01, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
  endtask

  task automatic test_lb_lbu();
    run_op("lb_0x103", 2'b01, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0);
    run_op("lbu_0x103", 2'b01, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 0);
  endtask

  task automatic test_sh();
    run_op("sh_0x102", 2'b10, 3'b001, 32'h102, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_sw_backpressure();
    run_op("sw_wait5", 2'b10, 3'b010, 32'h340, 32'hCAFE_F00D, 32'h5555_5555, 5);
  endtask

  task automatic test_misalign();
    run_op("lw_0x101", 2'b01, 3'b010, 32'h101, 32'h0, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_random();
    logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_rw = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rnd_nop_stall[%0d] got=%b exp=0", k, stall); end
        @(negedge clk);
        checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rnd_nop_valid[%0d] got=%b exp=0", k, bus_req_valid); end
        mem_rw = 2'b00;
      end
      run_op($sformatf("rnd%0d", k), 2'($urandom_range(1, 2)), f3_tab[$urandom_range(0, 7)],
             $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_rsp();
    run_op("lw_pre_reset", 2'b01, 3'b010, 32'h200, 32'h0, 32'h1357_9BDF, 0);
    mem_rw = 2'b01; funct3 = 3'b010; addr = 32'h204;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    mem_rw = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_req_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl valid=%b stall=%b exp=0/0", bus_req_valid, stall); end
    checks++; if (rdata !== 32'h0 || bus_addr !== 32'h0 || bus_be !== 4'h0) begin errors++; $display("FAIL rst_mid_regs rdata=%h addr=%h be=%b exp=0", rdata, bus_addr, bus_be); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    checks++; if (rdata !== 32'h0 || stall !== 1'b0 || bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_drop rdata=%h stall=%b valid=%b exp=0/0/0", rdata, stall, bus_req_valid); end
    @(negedge clk);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_hold rdata=%h exp=0", rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_sw_backpressure();
    test_misalign();
    test_random();
    test_reset_mid_rsp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the single-cycle core datapath: it consumes the memory control (`mem_rw`), effective address (ALU result) and store data (`rd2`) the core produces, and returns load data for write-back. It converts each memory instruction into one transaction on a valid/ready data-memory bus with byte enables. It holds the core with `stall` until that transaction completes.

## Interface
- `ADDR_W`, 32, address width on the core and bus sides
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_rw`  in  2  00 none, 01 load, 10 store, 11 treated as none
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W
- `addr`  in  ADDR_W  effective byte address
- `wdata`  in  32  store data, right-aligned
- `stall`  out  1  core must hold PC and suppress RF write
- `rdata`  out  32  load result, extended; valid in DONE
- `fault`  out  1  misaligned-access flag, valid in DONE
- `bus_req_valid`  out  1  request valid
- `bus_req_ready`  in  1  request accepted when valid && ready
- `bus_we`  out  1  1 = write
- `bus_addr`  out  ADDR_W  word-aligned address (`[1:0]`=0)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_rsp_valid`  in  1  response (loads and stores), single-cycle pulse
- `bus_rdata`  in  32  raw word read data

## Operation
- States: IDLE, REQ, RSP, DONE.
- IDLE: if `mem_rw` is 01/10, register the address, size, data and direction, drive bus outputs from those registers, and go to REQ; else stay.
- REQ: `bus_req_valid`=1; on `bus_req_ready` go to RSP.
- RSP: on `bus_rsp_valid` capture the extended load data (0 for stores) into `rdata`, then go to DONE.
- DONE: one cycle, then IDLE unconditionally. A memory op is never relaunched from DONE.
- `stall` = (IDLE && mem op present) || REQ || RSP. It is combinational, so the core's clock edge in DONE retires the instruction.
- Store lanes:
  - SB: `bus_be`=0001<<addr[1:0], `bus_wdata`={4{wdata[7:0]}}
  - SH: `bus_be`=0011<<{addr[1],1'b0}, `bus_wdata`={2{wdata[15:0]}}
  - SW: `bus_be`=1111, `bus_wdata`=wdata
- Loads: `bus_be`=1111 and `bus_we`=0. The byte/halfword is selected by addr[1:0]/addr[1], then sign-extended (B/H) or zero-extended (BU/HU).
- `bus_rsp_valid` is ignored outside RSP.

## Timing
- Reset: state IDLE, and `bus_req_valid`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `rdata`, `fault` all 0. Reset takes effect asynchronously, including mid-transaction; the outstanding response is dropped.
- Minimum latency with zero-wait bus (ready in REQ, response the next cycle): the op is seen at cycle 0, REQ at 1, RSP at 2, DONE at 3. `stall` is high for cycles 0–2, so the instruction takes 4 cycles.
- Bus rule: a response arrives no earlier than the cycle after request acceptance.
- While in REQ, all bus outputs are stable until accepted.
- `rdata` and `fault` hold their DONE values until the next capture.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - An H access with addr[0]=1 or a W access with addr[1:0]≠0 goes IDLE→DONE with no bus request.
  - In DONE, `fault`=1 and `rdata`=0. `stall` is high only in the issue cycle.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Address bits below the access's natural alignment are ignored (H masks [0], W masks [1:0]).
  - `fault` is tied to 0.

## Structure
- `lsu_pkg`: state enum, `mem_rw` encoding constants, `funct3` size constants.
- One sub-module, `lsu_align`: combinational store-lane steering/byte-enable generation and load extraction/extension. The FSM and registers stay in `lsu`.

## Test plan
- LW 0x100, ready in REQ, rsp next cycle with 0xDEADBEEF -> `bus_addr` 0x100, `bus_be` 1111, `stall` high 3 cycles, `rdata`=0xDEADBEEF in DONE.
- LB and then LBU at 0x103, `bus_rdata`=0x80000000 -> `rdata` 0xFFFFFF80 and 0x00000080 respectively.
- SH 0x102, wdata 0x1234ABCD -> `bus_addr` 0x100, `bus_be` 1100, `bus_wdata` 0xABCDABCD, `bus_we` 1, `rdata` 0.
- SW with `bus_req_ready` held low 5 cycles -> `bus_req_valid` and all bus outputs stable, `stall` high throughout, completes 2 cycles after ready.
- LW 0x101:
  - with `LSU_MISALIGN_TRAP_EN` -> no `bus_req_valid`, `fault`=1 for one cycle, `stall` only cycle 0.
  - without the macro -> `bus_addr` 0x100, `bus_be` 1111, `fault` 0.
- Assert `rst_n` low in RSP, then pulse `bus_rsp_valid` after release -> immediate IDLE, `bus_req_valid` 0, response ignored, `rdata` stays 0.
